// File: rtl/eth_pcs_rx_block_synch_ml.sv
// Multi-lane 64b/66b block synchroniser: one lock FSM per lane, slip requests and all-lanes lock.
// Optional post-slip holdoff enabled by defining ETH_PCS_RX_BLOCK_SYNCH_SLIP_HOLDOFF_EN.
module eth_pcs_rx_block_synch_ml #(
  parameter int unsigned N_LANES     = 4,
  parameter int unsigned SH_CNT_TH   = 64,
  parameter int unsigned SH_INVAL_TH = 16,
  parameter int unsigned SLIP_WAIT   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N_LANES-1:0]     i_valid,
  input  logic [2*N_LANES-1:0]   i_sync_hdr,
  output logic [N_LANES-1:0]     o_rx_lock,
  output logic [N_LANES-1:0]     o_slip,
  output logic                   o_all_lock
);

  localparam int unsigned ShW  = $clog2(SH_CNT_TH + 1);
  localparam int unsigned InvW = $clog2(SH_INVAL_TH + 1);
  localparam logic [ShW-1:0]  ShLast  = ShW'(SH_CNT_TH - 1);
  localparam logic [InvW-1:0] InvLast = InvW'(SH_INVAL_TH - 1);

  if (N_LANES < 1 || SH_INVAL_TH < 1 || SH_INVAL_TH > SH_CNT_TH || SLIP_WAIT < 1)
  begin : g_param_check
    $error("eth_pcs_rx_block_synch_ml: illegal parameter combination");
  end

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e          state_q       [N_LANES];
  state_e          state_d       [N_LANES];
  logic [ShW-1:0]  sh_cnt_q      [N_LANES];
  logic [ShW-1:0]  sh_cnt_d      [N_LANES];
  logic [InvW-1:0] inval_cnt_q   [N_LANES];
  logic [InvW-1:0] inval_cnt_d   [N_LANES];
  logic [N_LANES-1:0] sh_almost_q, sh_almost_d;
  logic [N_LANES-1:0] inval_almost_q, inval_almost_d;
  logic [N_LANES-1:0] hdr_good, hold_busy;
  logic [N_LANES-1:0] slip_q, slip_d;
  logic [N_LANES-1:0] rx_lock;
  logic               all_lock_q;

  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      hdr_good[k] = i_sync_hdr[2*k] ^ i_sync_hdr[2*k+1];
      rx_lock[k]  = (state_q[k] == StLocked);
    end
  end

`ifdef ETH_PCS_RX_BLOCK_SYNCH_SLIP_HOLDOFF_EN
  localparam int unsigned HoldW = $clog2(SLIP_WAIT + 1);

  logic [HoldW-1:0] hold_q [N_LANES];
  logic [HoldW-1:0] hold_d [N_LANES];

  // A slip reloads the holdoff; each valid beat during holdoff is consumed without effect.
  always_comb begin
    hold_d = hold_q;
    for (int k = 0; k < N_LANES; k++) begin
      hold_busy[k] = (hold_q[k] != '0);
      if (i_valid[k] && hold_busy[k]) hold_d[k] = hold_q[k] - HoldW'(1);
      if (slip_d[k]) hold_d[k] = HoldW'(SLIP_WAIT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < N_LANES; k++) hold_q[k] <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_busy = '0;
`endif

  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    inval_cnt_d = inval_cnt_q;
    slip_d      = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (i_valid[k] && !hold_busy[k]) begin
        unique case (state_q[k])
          StUnlocked: begin
            if (!hdr_good[k]) begin
              slip_d[k]      = 1'b1;
              sh_cnt_d[k]    = '0;
              inval_cnt_d[k] = '0;
            end else if (sh_almost_q[k]) begin
              state_d[k]     = StLocked;
              sh_cnt_d[k]    = '0;
              inval_cnt_d[k] = '0;
            end else begin
              sh_cnt_d[k] = sh_cnt_q[k] + ShW'(1);
            end
          end
          StLocked: begin
            // Lock loss wins over a coincident window end.
            if (!hdr_good[k] && inval_almost_q[k]) begin
              state_d[k]     = StUnlocked;
              slip_d[k]      = 1'b1;
              sh_cnt_d[k]    = '0;
              inval_cnt_d[k] = '0;
            end else if (sh_almost_q[k]) begin
              sh_cnt_d[k]    = '0;
              inval_cnt_d[k] = '0;
            end else begin
              sh_cnt_d[k] = sh_cnt_q[k] + ShW'(1);
              if (!hdr_good[k]) inval_cnt_d[k] = inval_cnt_q[k] + InvW'(1);
            end
          end
          default: state_d[k] = StUnlocked;
        endcase
      end
      // Registered one beat ahead so the next beat's threshold test is a single flop.
      sh_almost_d[k]    = (sh_cnt_d[k] == ShLast);
      inval_almost_d[k] = (inval_cnt_d[k] == InvLast);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < N_LANES; k++) begin
        state_q[k]     <= StUnlocked;
        sh_cnt_q[k]    <= '0;
        inval_cnt_q[k] <= '0;
      end
      sh_almost_q    <= {N_LANES{ShLast == '0}};
      inval_almost_q <= {N_LANES{InvLast == '0}};
      slip_q         <= '0;
      all_lock_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      inval_cnt_q    <= inval_cnt_d;
      sh_almost_q    <= sh_almost_d;
      inval_almost_q <= inval_almost_d;
      slip_q         <= slip_d;
      all_lock_q     <= &rx_lock;
    end
  end

  assign o_rx_lock  = rx_lock;
  assign o_slip     = slip_q;
  assign o_all_lock = all_lock_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_synch_ml.sv
// Scoreboard bench for eth_pcs_rx_block_synch_ml (4 lanes, default thresholds).
module tb_eth_pcs_rx_block_synch_ml;

  localparam int NL = 4;
  localparam int CNT_TH = 64;
  localparam int INV_TH = 16;
  localparam int WAIT_B = 2;
`ifdef ETH_PCS_RX_BLOCK_SYNCH_SLIP_HOLDOFF_EN
  localparam bit HOLDOFF = 1'b1;
`else
  localparam bit HOLDOFF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] vld = '0;
  logic [2*NL-1:0] hdr = '0;
  logic [NL-1:0] rx_lock, slip;
  logic          all_lock;

  eth_pcs_rx_block_synch_ml #(
    .N_LANES(NL), .SH_CNT_TH(CNT_TH), .SH_INVAL_TH(INV_TH), .SLIP_WAIT(WAIT_B)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_sync_hdr(hdr),
    .o_rx_lock(rx_lock), .o_slip(slip), .o_all_lock(all_lock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL-1:0] lock;
    logic [NL-1:0] slp;
    logic          all;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  int m_sh[NL], m_inv[NL], m_hold[NL];
  bit [NL-1:0] m_lock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour straight from the lane rules; expected outputs queued per beat.
  task automatic model(input logic r, input logic [NL-1:0] v, input logic [2*NL-1:0] h);
    exp_t e;
    e.all = r ? 1'b0 : &m_lock;
    e.slp = '0;
    for (int k = 0; k < NL; k++) begin
      if (r) begin
        m_sh[k] = 0; m_inv[k] = 0; m_hold[k] = 0; m_lock[k] = 1'b0;
      end else if (v[k]) begin
        if (m_hold[k] > 0) begin
          m_hold[k]--;
        end else begin
          bit good;
          good = (h[2*k+:2] == 2'b01) || (h[2*k+:2] == 2'b10);
          if (!m_lock[k]) begin
            if (good) begin
              m_sh[k]++;
              if (m_sh[k] == CNT_TH) begin m_lock[k] = 1'b1; m_sh[k] = 0; m_inv[k] = 0; end
            end else begin
              e.slp[k] = 1'b1; m_sh[k] = 0; m_inv[k] = 0;
            end
          end else begin
            m_sh[k]++;
            if (!good) m_inv[k]++;
            if (m_inv[k] == INV_TH) begin
              m_lock[k] = 1'b0; e.slp[k] = 1'b1; m_sh[k] = 0; m_inv[k] = 0;
            end else if (m_sh[k] == CNT_TH) begin
              m_sh[k] = 0; m_inv[k] = 0;
            end
          end
          if (e.slp[k] && HOLDOFF) m_hold[k] = WAIT_B;
        end
      end
    end
    e.lock = m_lock;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [NL-1:0] v, input logic [2*NL-1:0] h);
    exp_t e;
    rst = r; vld = v; hdr = h;
    model(r, v, h);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("rx_lock", 32'(rx_lock), 32'(e.lock));
      check_eq("slip", 32'(slip), 32'(e.slp));
      check_eq("all_lock", 32'(all_lock), 32'(e.all));
    end
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [2*NL-1:0] all_good();
    logic [2*NL-1:0] h;
    for (int k = 0; k < NL; k++) h[2*k+:2] = good_hdr();
    return h;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic do_reset();
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
  endtask

  initial begin
    logic [2*NL-1:0] h;
    logic [NL-1:0] v;
    int lock_beat;

    // Reset state
    do_reset();
    check_eq("reset_lock", 32'(rx_lock), 32'h0);
    check_eq("reset_slip", 32'(slip), 32'h0);
    check_eq("reset_all", 32'(all_lock), 32'h0);

    // Acquisition on all lanes
    for (int b = 1; b <= CNT_TH + 1; b++) begin
      step(1'b0, '1, all_good());
      if (b == CNT_TH - 1) check_eq("acq_lock_b63", 32'(rx_lock), 32'h0);
      if (b == CNT_TH) begin
        check_eq("acq_lock_b64", 32'(rx_lock), 32'hF);
        check_eq("acq_all_b64", 32'(all_lock), 32'h0);
      end
      if (b == CNT_TH + 1) check_eq("acq_all_b65", 32'(all_lock), 32'h1);
    end

    // Lane 2: 15 bad in one window keeps lock; 16 bad in the next loses it
    for (int b = 1; b < CNT_TH; b++) begin
      h = all_good();
      if (b <= INV_TH - 1) h[5:4] = bad_hdr();
      step(1'b0, '1, h);
    end
    check_eq("inv15_lock", 32'(rx_lock), 32'hF);
    for (int b = 1; b <= INV_TH + 1; b++) begin
      h = all_good();
      if (b <= INV_TH) h[5:4] = bad_hdr();
      step(1'b0, '1, h);
      if (b == INV_TH) begin
        check_eq("inv16_lock", 32'(rx_lock), 32'hB);
        check_eq("inv16_slip", 32'(slip), 32'h4);
        check_eq("inv16_all", 32'(all_lock), 32'h1);
      end
      if (b == INV_TH + 1) begin
        check_eq("inv16_slip_end", 32'(slip), 32'h0);
        check_eq("inv16_all_fall", 32'(all_lock), 32'h0);
      end
    end

    // Lane 1 bad header at beat 10 while unlocked
    do_reset();
    lock_beat = CNT_TH + 10 + (HOLDOFF ? WAIT_B : 0);
    for (int b = 1; b <= lock_beat + 1; b++) begin
      h = all_good();
      if (b == 10) h[3:2] = 2'b00;
      step(1'b0, '1, h);
      if (b == 10) check_eq("l1_slip", 32'(slip), 32'h2);
      if (b == 11) check_eq("l1_slip_once", 32'(slip), 32'h0);
      if (b == CNT_TH) check_eq("l1_others_lock", 32'(rx_lock), 32'hD);
      if (b == lock_beat - 1) check_eq("l1_not_yet", 32'(rx_lock[1]), 32'h0);
      if (b == lock_beat) check_eq("l1_relock", 32'(rx_lock[1]), 32'h1);
    end

    // Lane 0 valid toggling, bad headers on the idle cycles
    do_reset();
    for (int i = 0; i < 2 * CNT_TH + 2; i++) begin
      h = '0;
      if (i % 2 == 0) h[1:0] = good_hdr();
      step(1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0000, h);
      if (i % 2 == 1) check_eq("tog_no_slip", 32'(slip[0]), 32'h0);
      if (i == 2 * CNT_TH - 4) check_eq("tog_not_yet", 32'(rx_lock[0]), 32'h0);
      if (i == 2 * CNT_TH - 2) check_eq("tog_lock", 32'(rx_lock[0]), 32'h1);
    end

    // Lane 3 bad on every beat
    do_reset();
    for (int b = 1; b <= 12; b++) begin
      h = '0;
      h[7:6] = bad_hdr();
      step(1'b0, 4'b1000, h);
      check_eq("l3_slip", 32'(slip),
               (!HOLDOFF || ((b - 1) % (WAIT_B + 1) == 0)) ? 32'h8 : 32'h0);
    end

    // Mid-operation reset, then re-lock
    do_reset();
    for (int b = 1; b <= CNT_TH + 1; b++) step(1'b0, '1, all_good());
    check_eq("pre_rst_all", 32'(all_lock), 32'h1);
    step(1'b1, '1, all_good());
    check_eq("mid_rst_lock", 32'(rx_lock), 32'h0);
    check_eq("mid_rst_all", 32'(all_lock), 32'h0);
    for (int b = 1; b <= CNT_TH; b++) step(1'b0, '1, all_good());
    check_eq("relock", 32'(rx_lock), 32'hF);

    // Random traffic: sparse bad headers and gaps, checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      h = all_good();
      for (int k = 0; k < NL; k++)
        if ($urandom_range(0, 7) == 0) h[2*k+:2] = bad_hdr();
      v = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, v, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/eth_pcs_rx_block_synch_ml.md
# eth_pcs_rx_block_synch_ml

Multi-lane, parametrised 64b/66b block synchroniser for the Ethernet PCS receive path. It sits between the RX gearbox and the descrambler/lane-deskew logic, with one independent Clause-49-style lock state machine per lane. Each lane's machine drives the gearbox slip request and a lock indication. The block also produces an aggregate all-lanes-locked flag for the deskew stage.

## Interface
Parameters:
- N_LANES, 4, number of independent lanes (≥1)
- SH_CNT_TH, 64, sync headers per test window / needed to acquire lock
- SH_INVAL_TH, 16, invalid headers within one window that cause lock loss (1 ≤ SH_INVAL_TH ≤ SH_CNT_TH)
- SLIP_WAIT, 2, valid beats ignored after a slip (used only with the macro, ≥1)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  N_LANES  per-lane header-valid strobe from gearbox
- i_sync_hdr  in  2*N_LANES  lane k header at bits [2k+1:2k]
- o_rx_lock  out  N_LANES  per-lane block lock
- o_slip  out  N_LANES  per-lane one-cycle slip request to gearbox
- o_all_lock  out  1  AND of all lane locks, registered

## Operation
- Header is good when it equals 2'b01 (data) or 2'b10 (ctrl); 2'b00 and 2'b11 are bad.
- Per lane: sh_cnt and inval_cnt, each $clog2(TH+1) bits wide, plus a lock flag.
- Lane state advances only on beats with i_valid[k]=1. On beats with i_valid[k]=0, state is frozen and o_slip[k]=0.
- UNLOCKED:
  - Good header: sh_cnt+1. When sh_cnt reaches SH_CNT_TH, go to LOCKED and clear both counters.
  - Bad header: slip, clear both counters, stay UNLOCKED.
- LOCKED:
  - Every header: sh_cnt+1. A bad header also does inval_cnt+1.
  - If inval_cnt reaches SH_INVAL_TH: go to UNLOCKED, slip, clear both counters. This takes priority over window end on the same beat.
  - Else if sh_cnt reaches SH_CNT_TH (window end): clear both counters, stay LOCKED.
- Counter compares are pre-computed one beat ahead (almost-threshold registers) for timing. This must not change the beat-exact behaviour above.
- Lanes are fully independent. Simultaneous slips on several lanes are legal.

## Timing
- Reset values: o_rx_lock=0, o_slip=0, o_all_lock=0, all counters 0, holdoff cleared.
- A reset asserted mid-operation takes effect on the next edge, with the same values.
- o_slip[k] is registered. It pulses high for exactly one cycle, on the cycle after the bad beat that triggers the slip.
- o_rx_lock[k] changes on the cycle after the beat that completes acquisition or triggers loss.
- o_all_lock follows the AND of o_rx_lock one cycle later. It falls one cycle after any lane lock falls.
- Acquisition needs exactly SH_CNT_TH consecutive good valid beats, independent of gaps in i_valid.

## Configuration
- Macro: ETH_PCS_RX_BLOCK_SYNCH_SLIP_HOLDOFF_EN.
- Defined:
  - After a slip, lane k ignores the next SLIP_WAIT valid beats while the gearbox settles.
  - During holdoff: no counting, no slip, lock stays 0.
  - Counting resumes on the following valid beat.
- Undefined:
  - No holdoff. Every bad beat while UNLOCKED produces a slip.
  - SLIP_WAIT is unused.

## Test plan
- Reset, then 64 good headers on all 4 lanes with i_valid=1 every cycle -> o_rx_lock=4'hF on the cycle after beat 64; o_all_lock=1 one cycle later.
- Lane 1 unlocked, bad header 2'b00 at beat 10 -> o_slip=4'b0010 for one cycle on the next cycle. Lock then needs 64 further good beats (at beat 74).
- Lane 2 locked: 15 bad headers in a 64-beat window -> stays locked and the counters clear at window end. Next window with 16 bad headers -> o_rx_lock[2] falls and o_slip[2] pulses one cycle after the 16th bad beat; o_all_lock falls one cycle after that.
- i_valid toggled 1/0 every cycle on lane 0 -> lock after the 64th valid beat (~128 cycles); o_slip[0]=0 on every i_valid=0 cycle, even with bad i_sync_hdr.
- With the macro and SLIP_WAIT=2: bad headers on lane 3 on every beat -> slips on beats 1, 4, 7, …. Without the macro -> a slip after every bad beat.
- Lane 0 locked and i_reset pulsed for one cycle -> all outputs 0 on the following cycle; re-lock after 64 good beats.
